// File: rtl/fifo_stream_reader_pkg.sv
// Shared FIFO parameters for the FIFO blocks and the stream read adapter.
package fifo_stream_reader_pkg;

    localparam int FIFO_DATA_WIDTH  = 8;
    localparam int FIFO_COUNT_WIDTH = 16;

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus valid/ready stream; 'master' is the reader, 'slave' the FIFO/consumer side.
interface fifo_stream_reader_if
    import fifo_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH
);

    logic                  FIFO_EMPTY;
    logic [DATA_WIDTH-1:0] FIFO_DATA;
    logic                  FIFO_RD_EN;
    logic                  M_VALID;
    logic                  M_READY;
    logic [DATA_WIDTH-1:0] M_DATA;

    modport master (
        input  FIFO_EMPTY, FIFO_DATA, M_READY,
        output FIFO_RD_EN, M_VALID, M_DATA
    );

    modport slave (
        output FIFO_EMPTY, FIFO_DATA, M_READY,
        input  FIFO_RD_EN, M_VALID, M_DATA
    );

endinterface

// File: rtl/fifo_stream_reader_buf.sv
// Two-entry circular word buffer: head pointer, occupancy and registered head output.
module fifo_stream_reader_buf
    import fifo_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
    input  logic                  FCLK,
    input  logic                  FRST,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [1:0]            occ
);

    logic [DATA_WIDTH-1:0] entry [2];
    logic                  head;
    logic                  wr_idx;

    // Slot just past the tail; identical to (post-pop head + occ - pop) mod 2.
    assign wr_idx    = head ^ occ[0];
    assign head_data = entry[head];

    // NOTE: storage is reset too, because the stream output must read 0 out of reset.
    always_ff @(posedge FCLK or posedge FRST) begin
        if (FRST) begin
            entry[0] <= '0;
            entry[1] <= '0;
            head     <= 1'b0;
            occ      <= 2'd0;
        end else begin
            // NOTE: non-blocking so every register updates from pre-edge values.
            if (push) begin
                entry[wr_idx] <= push_data;
            end
            if (pop) begin
                head <= ~head;
            end
            unique case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_stream_reader.sv
// FIFO-to-stream read adapter with lookahead; STREAM_READER_COUNT_EN adds the WORD_COUNT output.
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
    input  logic                        FCLK,
    input  logic                        FRST,
`ifdef STREAM_READER_COUNT_EN
    output logic [FIFO_COUNT_WIDTH-1:0] WORD_COUNT,
`endif
    fifo_stream_reader_if.master        bus
);

    logic       inflight;
    logic       pop;
    logic [1:0] occ;
    logic [2:0] pending;

    assign pop         = bus.M_VALID && bus.M_READY;
    assign bus.M_VALID = (occ != 2'd0);

    // Words held or arriving after this edge; pop implies occ >= 1, so no underflow.
    assign pending        = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign bus.FIFO_RD_EN = !FRST && !bus.FIFO_EMPTY && (pending < 3'd2);

    always_ff @(posedge FCLK or posedge FRST) begin
        if (FRST) begin
            inflight <= 1'b0;
        end else begin
            inflight <= bus.FIFO_RD_EN;
        end
    end

    fifo_stream_reader_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .FCLK      (FCLK),
        .FRST      (FRST),
        .push      (inflight),
        .push_data (bus.FIFO_DATA),
        .pop       (pop),
        .head_data (bus.M_DATA),
        .occ       (occ)
    );

`ifdef STREAM_READER_COUNT_EN
    always_ff @(posedge FCLK or posedge FRST) begin
        if (FRST) begin
            WORD_COUNT <= '0;
        end else if (pop) begin
            WORD_COUNT <= WORD_COUNT + FIFO_COUNT_WIDTH'(1);
        end
    end
`else
    // No word counter in this build.
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboarded bench for fifo_stream_reader: queue-based FIFO model, randomized traffic and backpressure.
module tb_fifo_stream_reader;
    import fifo_stream_reader_pkg::*;

    logic FCLK = 1'b0;
    logic FRST;

    fifo_stream_reader_if #(.DATA_WIDTH(8)) bus();

`ifdef STREAM_READER_COUNT_EN
    logic [15:0] word_count;
`endif

    fifo_stream_reader #(.DATA_WIDTH(8)) dut (
        .FCLK       (FCLK),
        .FRST       (FRST),
`ifdef STREAM_READER_COUNT_EN
        .WORD_COUNT (word_count),
`endif
        .bus        (bus)
    );

    always #5 FCLK = ~FCLK;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    logic [7:0] fifo_q [$];
    logic [7:0] exp_q  [$];
    int         rd_log [$];
    int         pop_log[$];
    logic       rd_s        = 1'b0;
    logic       force_empty = 1'b0;
    int         outstanding = 0;
    logic       prev_stall  = 1'b0;
    logic [7:0] prev_data   = '0;
    logic [15:0] model_count = '0;
    int         r0, p0;
    logic [7:0] w [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge FCLK) cyc <= cyc + 1;

    // Monitor: pops the scoreboard on every handshake and checks stream rules.
    always @(negedge FCLK) begin
        if (FRST) begin
            rd_s        = 1'b0;
            outstanding = 0;
            prev_stall  = 1'b0;
            model_count = '0;
        end else begin
            check("rd_while_empty", 32'(bus.FIFO_RD_EN && bus.FIFO_EMPTY), 32'd0);
            if (prev_stall) begin
                check("valid_held", 32'(bus.M_VALID), 32'd1);
                check("data_held", 32'(bus.M_DATA), 32'(prev_data));
            end
`ifdef STREAM_READER_COUNT_EN
            check("word_count", 32'(word_count), 32'(model_count));
`endif
            if (bus.M_VALID && bus.M_READY) begin
                check("stream_word_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    check("stream_data", 32'(bus.M_DATA), 32'(exp_q.pop_front()));
                end
                pop_log.push_back(cyc);
                outstanding--;
                model_count++;
            end
            if (bus.FIFO_RD_EN) begin
                rd_log.push_back(cyc);
                outstanding++;
            end
            check("occ_plus_inflight_le2", 32'(outstanding <= 2), 32'd1);
            rd_s       = bus.FIFO_RD_EN;
            prev_stall = bus.M_VALID && !bus.M_READY;
            prev_data  = bus.M_DATA;
        end
    end

    task automatic update_empty();
        bus.FIFO_EMPTY = force_empty || (fifo_q.size() == 0);
    endtask

    task automatic push(input logic [7:0] d);
        fifo_q.push_back(d);
        exp_q.push_back(d);
        update_empty();
    endtask

    // One clock: the FIFO model answers last cycle's read with registered data.
    task automatic tick();
        @(posedge FCLK);
        #1;
        if (rd_s && fifo_q.size() != 0) bus.FIFO_DATA = fifo_q.pop_front();
        else                            bus.FIFO_DATA = 8'($urandom);
        update_empty();
    endtask

    task automatic apply_reset();
        FRST = 1'b1;
        fifo_q.delete();
        exp_q.delete();
        update_empty();
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || outstanding != 0) && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(exp_q.size() == 0 && outstanding == 0), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        FRST          = 1'b1;
        bus.M_READY   = 1'b0;
        bus.FIFO_DATA = '0;
        update_empty();

        // Reset state with a non-empty FIFO: reset must gate the read.
        push(8'h11); push(8'h22); push(8'h33);
        tick(); tick();
        check("reset_valid", 32'(bus.M_VALID), 32'd0);
        check("reset_data", 32'(bus.M_DATA), 32'd0);
        check("reset_rd_en", 32'(bus.FIFO_RD_EN), 32'd0);

        // Three words, consumer always ready.
        bus.M_READY = 1'b1;
        FRST = 1'b0;
        r0 = rd_log.size(); p0 = pop_log.size();
        repeat (8) tick();
        check("b_reads", 32'(rd_log.size() - r0), 32'd3);
        check("b_pops", 32'(pop_log.size() - p0), 32'd3);
        if (rd_log.size() - r0 >= 3 && pop_log.size() - p0 >= 3) begin
            for (int k = 1; k < 3; k++) check("b_rd_consecutive", 32'(rd_log[r0+k]), 32'(rd_log[r0] + k));
            for (int k = 0; k < 3; k++) check("b_pop_latency", 32'(pop_log[p0+k]), 32'(rd_log[r0] + 2 + k));
        end

        // Backpressure: only two reads, head word held, then gap-free drain.
        bus.M_READY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            w[i] = 8'($urandom_range(1, 255));
            push(w[i]);
        end
        r0 = rd_log.size(); p0 = pop_log.size();
        repeat (8) tick();
        check("c_reads_stalled", 32'(rd_log.size() - r0), 32'd2);
        check("c_valid_stalled", 32'(bus.M_VALID), 32'd1);
        check("c_data_stalled", 32'(bus.M_DATA), 32'(w[0]));
        bus.M_READY = 1'b1;
        repeat (10) tick();
        check("c_pops", 32'(pop_log.size() - p0), 32'd5);
        if (pop_log.size() - p0 >= 5) begin
            for (int k = 1; k < 5; k++) check("c_no_gap", 32'(pop_log[p0+k]), 32'(pop_log[p0] + k));
        end

        // Ready toggling every cycle over eight words.
        p0 = pop_log.size();
        for (int i = 0; i < 8; i++) push(8'($urandom));
        repeat (30) begin
            tick();
            bus.M_READY = ~bus.M_READY;
        end
        bus.M_READY = 1'b1;
        wait_drain("d_drain", 40);
        check("d_pops", 32'(pop_log.size() - p0), 32'd8);

        // Single word: FIFO goes empty right after the read.
        r0 = rd_log.size(); p0 = pop_log.size();
        push(8'h5a);
        repeat (5) tick();
        check("e1_reads", 32'(rd_log.size() - r0), 32'd1);
        check("e1_pops", 32'(pop_log.size() - p0), 32'd1);

        // EMPTY falls for one cycle then rises: the in-flight word still lands.
        force_empty = 1'b1;
        push(8'h01); push(8'h02); push(8'h03);
        r0 = rd_log.size(); p0 = pop_log.size();
        tick();
        force_empty = 1'b0;
        update_empty();
        tick();
        force_empty = 1'b1;
        update_empty();
        repeat (5) tick();
        check("e2_reads", 32'(rd_log.size() - r0), 32'd1);
        check("e2_pops", 32'(pop_log.size() - p0), 32'd1);
        if (rd_log.size() > r0 && pop_log.size() > p0)
            check("e2_first_latency", 32'(pop_log[p0]), 32'(rd_log[r0] + 2));
        force_empty = 1'b0;
        update_empty();
        wait_drain("e2_drain", 20);
        check("e2_total_pops", 32'(pop_log.size() - p0), 32'd3);

        // Reset mid-stream with a word buffered and one in flight.
        for (int i = 0; i < 5; i++) push(8'($urandom_range(1, 255)));
        tick(); tick();
        check("f_pre_valid", 32'(bus.M_VALID), 32'd1);
        apply_reset();
        #1;
        check("f_valid", 32'(bus.M_VALID), 32'd0);
        check("f_data", 32'(bus.M_DATA), 32'd0);
        check("f_rd_en", 32'(bus.FIFO_RD_EN), 32'd0);
        tick(); tick();
        FRST = 1'b0;
        r0 = rd_log.size(); p0 = pop_log.size();
        push(8'hc3); push(8'h3c);
        repeat (6) tick();
        check("f_reads", 32'(rd_log.size() - r0), 32'd2);
        check("f_pops", 32'(pop_log.size() - p0), 32'd2);
        if (rd_log.size() > r0 && pop_log.size() > p0)
            check("f_latency", 32'(pop_log[p0]), 32'(rd_log[r0] + 2));

        // Randomized traffic, backpressure and empty glitches.
        p0 = pop_log.size();
        r0 = 0;
        repeat (400) begin
            if ($urandom_range(0, 9) < 4 && fifo_q.size() < 12) begin
                push(8'($urandom));
                r0++;
            end
            bus.M_READY = ($urandom_range(0, 3) != 0);
            force_empty = ($urandom_range(0, 9) == 0);
            update_empty();
            tick();
        end
        force_empty = 1'b0;
        update_empty();
        bus.M_READY = 1'b1;
        wait_drain("g_drain", 100);
        check("g_pops", 32'(pop_log.size() - p0), 32'(r0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
